turret_cmd_sequencer: RTL and testbench
=======================================

// Module: turret_cmd_sequencer
// PURPOSE
//   Arbitrates pan/tilt/fire ownership between manual switch commands and automatic targeting.
//   Tracks bounded X/Y position counters and sequences the fire/recoil/cooldown cycle.
//   Emits the per-axis and trigger command codes consumed by the servo PWM stage.
//   Sits between the switch/target front end and the PWM generators.
// PARAMETERS
//   POS_W           25        width of X/Y position counters
//   X_MAX           22727272  upper X bound (lower bound is 0)
//   Y_MAX           22727272  upper Y bound (lower bound is 0)
//   STEP_DIV        1         clocks per position step (>=1); 1 = step every clock
//   CNT_W           31        width of fire-sequence timer
//   FIRE_CYCLES     22727272  clocks spent in FIRE (>=1)
//   RECOIL_CYCLES   22727272  clocks spent in RECOIL (>=1)
//   COOLDOWN_CYCLES 4545454   clocks spent in COOLDOWN (>=1)
// PORTS
//   i_Clk          in   1      system clock, all state on rising edge
//   i_Rst_n        in   1      asynchronous reset, active-low
//   i_Auto_Mode    in   1      requested mode: 1 = automatic, 0 = manual
//   i_Switch_1..4  in   1 ea   manual left / right / up / down levels, active-high
//   i_Fire_n       in   1      manual fire button, active-low
//   i_Auto_Valid   in   1      automatic command fields are valid this cycle
//   i_Auto_X_Dir   in   2      00 stop, 01 left, 10 right, 11 stop
//   i_Auto_Y_Dir   in   2      00 stop, 01 up, 10 down, 11 stop
//   i_Auto_On_Tgt  in   1      target centred
//   i_Auto_Fire    in   1      automatic fire request
//   o_X_Cmd        out  4      0 idle, 1 left, 2 right, 5 hold
//   o_Y_Cmd        out  4      0 idle, 1 up, 2 down, 5 hold
//   o_Fire_Cmd     out  4      0 rest, 1 fire, 2 recoil
//   o_X_Pos        out  POS_W  current X position
//   o_Y_Pos        out  POS_W  current Y position
//   o_Auto_Active  out  1      1 while mode FSM is in AUTO
//   o_Shot_Pulse   out  1      one-clock pulse on entry to FIRE
//   o_Busy         out  1      fire FSM not IDLE, or mode FSM in a transition state
// BEHAVIOUR
//   Reset (async, i_Rst_n=0): every output and counter clears to 0. Mode FSM enters MANUAL; fire FSM enters IDLE.
//     Applies immediately even mid-shot, with no completion of the sequence.
//   Mode FSM: MANUAL, TO_AUTO, AUTO, TO_MANUAL.
//     MANUAL->TO_AUTO when i_Auto_Mode=1 and fire FSM is IDLE.
//     AUTO->TO_MANUAL when i_Auto_Mode=0 and fire FSM is IDLE.
//     A mode change requested while the fire FSM is busy is deferred until it returns to IDLE.
//     TO_AUTO / TO_MANUAL last exactly 1 clock, then go to AUTO / MANUAL.
//     In a transition state both axes output 5, no position steps occur, and fire is not accepted.
//   Axis request:
//     MANUAL: neg = own-neg switch AND NOT own-pos switch; pos likewise. Both switches set = no request.
//     AUTO: taken from the Dir fields only when i_Auto_Valid=1; otherwise no request.
//   Axis output, registered with 1-clock latency from the request:
//     fire FSM not IDLE -> 5 (axes frozen);
//     neg request with pos>0, or pos request with pos<MAX -> 1 / 2;
//     otherwise -> 0, including a request pushing into a bound.
//   Position: a shared step-tick counter wraps at STEP_DIV-1. On each tick, an axis outputting 1 decrements
//     and one outputting 2 increments. Result clamps to [0, MAX]; never wraps.
//   Fire FSM: IDLE, FIRE, RECOIL, COOLDOWN.
//     IDLE->FIRE when the mode FSM is MANUAL with i_Fire_n=0, or AUTO with i_Auto_Valid & i_Auto_On_Tgt & i_Auto_Fire.
//     Fire is accepted only in MANUAL/AUTO: if the same edge moves MANUAL/AUTO->TO_AUTO/TO_MANUAL, the mode change wins and fire is ignored.
//     FIRE lasts FIRE_CYCLES clocks, RECOIL lasts RECOIL_CYCLES, COOLDOWN lasts COOLDOWN_CYCLES, then IDLE.
//     The timer reloads on every state entry.
//     o_Fire_Cmd: FIRE=1, RECOIL=2, IDLE/COOLDOWN=0.
//     o_Shot_Pulse is high on the first FIRE clock only.
//   Fire requests are level-sensitive and not queued. A request held through COOLDOWN refires on the first IDLE clock.
// TESTING  (X_MAX=Y_MAX=7, STEP_DIV=1, FIRE=3, RECOIL=2, COOLDOWN=4)
//   Manual hold Switch_2 for 10 clocks from X=0 -> X_Cmd=2 and X counts 1..7, stops at 7, then X_Cmd=0.
//   Switch_1 and Switch_2 both high -> X_Cmd=0 and X_Pos unchanged. Switch_3 at Y=0 -> Y_Cmd=0 and Y stays 0.
//   Pulse i_Fire_n low 1 clock -> o_Shot_Pulse 1 clk; Fire_Cmd 1 for 3 clks, 2 for 2 clks, 0; o_Busy low 9 clks after entry.
//   Raise i_Auto_Mode during FIRE -> stays MANUAL until IDLE, then 1 clk of 5/5 (TO_AUTO), then o_Auto_Active=1.
//   AUTO with X_Dir=10 but i_Auto_Valid=0 -> X_Cmd=0. Valid+On_Tgt+Fire -> shot fires and axes read 5 during it.
//   Assert i_Rst_n=0 mid-RECOIL -> all outputs 0 at once; after release, MANUAL/IDLE and positions read 0.

Source files
------------

// File: rtl/turret_cmd_sequencer.sv
// Turret command sequencer: manual/auto ownership arbitration, bounded X/Y position
// tracking and the fire -> recoil -> cooldown trigger cycle feeding the servo PWM stage.
module turret_cmd_sequencer #(
  parameter int POS_W           = 25,
  parameter int X_MAX           = 22727272,
  parameter int Y_MAX           = 22727272,
  parameter int STEP_DIV        = 1,
  parameter int CNT_W           = 31,
  parameter int FIRE_CYCLES     = 22727272,
  parameter int RECOIL_CYCLES   = 22727272,
  parameter int COOLDOWN_CYCLES = 4545454
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Auto_Mode,
  input  logic             i_Switch_1,
  input  logic             i_Switch_2,
  input  logic             i_Switch_3,
  input  logic             i_Switch_4,
  input  logic             i_Fire_n,
  input  logic             i_Auto_Valid,
  input  logic [1:0]       i_Auto_X_Dir,
  input  logic [1:0]       i_Auto_Y_Dir,
  input  logic             i_Auto_On_Tgt,
  input  logic             i_Auto_Fire,
  output logic [3:0]       o_X_Cmd,
  output logic [3:0]       o_Y_Cmd,
  output logic [3:0]       o_Fire_Cmd,
  output logic [POS_W-1:0] o_X_Pos,
  output logic [POS_W-1:0] o_Y_Pos,
  output logic             o_Auto_Active,
  output logic             o_Shot_Pulse,
  output logic             o_Busy
);

  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [3:0] CMD_IDLE = 4'd0;
  localparam logic [3:0] CMD_NEG  = 4'd1;
  localparam logic [3:0] CMD_POS  = 4'd2;
  localparam logic [3:0] CMD_HOLD = 4'd5;

  typedef enum logic [1:0] {M_MANUAL, M_TO_AUTO, M_AUTO, M_TO_MANUAL} mode_t;
  typedef enum logic [1:0] {F_IDLE, F_FIRE, F_RECOIL, F_COOLDOWN} fire_t;

  mode_t            mode_q, mode_nxt;
  fire_t            fire_q, fire_nxt;
  logic [CNT_W-1:0] timer_q, timer_nxt;
  logic [SW-1:0]    step_q;
  logic             step_tick;
  logic             fire_req, fire_ok, hold;
  logic             x_neg, x_pos, y_neg, y_pos;
  logic [3:0]       x_cmd_nxt, y_cmd_nxt;

  function automatic logic [3:0] axis_cmd(input logic hold_a, input logic neg, input logic pos,
                                          input logic at_min, input logic at_max);
    if (hold_a)              return CMD_HOLD;
    else if (neg && !at_min) return CMD_NEG;
    else if (pos && !at_max) return CMD_POS;
    else                     return CMD_IDLE;
  endfunction

  // Saturating step: never moves past 0 or the axis bound.
  function automatic logic [POS_W-1:0] pos_step(input logic [POS_W-1:0] pos, input logic [3:0] cmd,
                                                input logic [POS_W-1:0] max_v);
    if (cmd == CMD_NEG && pos != '0)         return pos - 1'b1;
    else if (cmd == CMD_POS && pos != max_v) return pos + 1'b1;
    else                                     return pos;
  endfunction

  always_comb begin
    mode_nxt = mode_q;
    case (mode_q)
      M_MANUAL:    if (i_Auto_Mode && fire_q == F_IDLE) mode_nxt = M_TO_AUTO;
      M_TO_AUTO:   mode_nxt = M_AUTO;
      M_AUTO:      if (!i_Auto_Mode && fire_q == F_IDLE) mode_nxt = M_TO_MANUAL;
      M_TO_MANUAL: mode_nxt = M_MANUAL;
      default:     mode_nxt = M_MANUAL;
    endcase
  end

  // A mode change on the same edge takes priority over a fire request.
  assign fire_req = (mode_q == M_MANUAL && !i_Fire_n) ||
                    (mode_q == M_AUTO && i_Auto_Valid && i_Auto_On_Tgt && i_Auto_Fire);
  assign fire_ok  = fire_req && (mode_nxt == mode_q);

  always_comb begin
    fire_nxt  = fire_q;
    timer_nxt = (timer_q != '0) ? timer_q - 1'b1 : timer_q;
    case (fire_q)
      F_IDLE: if (fire_ok) begin
        fire_nxt  = F_FIRE;
        timer_nxt = CNT_W'(FIRE_CYCLES - 1);
      end
      F_FIRE: if (timer_q == '0) begin
        fire_nxt  = F_RECOIL;
        timer_nxt = CNT_W'(RECOIL_CYCLES - 1);
      end
      F_RECOIL: if (timer_q == '0) begin
        fire_nxt  = F_COOLDOWN;
        timer_nxt = CNT_W'(COOLDOWN_CYCLES - 1);
      end
      F_COOLDOWN: if (timer_q == '0) begin
        fire_nxt  = F_IDLE;
        timer_nxt = '0;
      end
      default: fire_nxt = F_IDLE;
    endcase
  end

  always_comb begin
    x_neg = 1'b0;
    x_pos = 1'b0;
    y_neg = 1'b0;
    y_pos = 1'b0;
    if (mode_nxt == M_MANUAL) begin
      x_neg = i_Switch_1 & ~i_Switch_2;
      x_pos = i_Switch_2 & ~i_Switch_1;
      y_neg = i_Switch_3 & ~i_Switch_4;
      y_pos = i_Switch_4 & ~i_Switch_3;
    end else if (mode_nxt == M_AUTO && i_Auto_Valid) begin
      x_neg = (i_Auto_X_Dir == 2'b01);
      x_pos = (i_Auto_X_Dir == 2'b10);
      y_neg = (i_Auto_Y_Dir == 2'b01);
      y_pos = (i_Auto_Y_Dir == 2'b10);
    end
  end

  assign hold      = (mode_nxt == M_TO_AUTO) || (mode_nxt == M_TO_MANUAL) || (fire_nxt != F_IDLE);
  assign x_cmd_nxt = axis_cmd(hold, x_neg, x_pos, o_X_Pos == '0, o_X_Pos == POS_W'(X_MAX));
  assign y_cmd_nxt = axis_cmd(hold, y_neg, y_pos, o_Y_Pos == '0, o_Y_Pos == POS_W'(Y_MAX));
  assign step_tick = (step_q == SW'(STEP_DIV - 1));

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      mode_q       <= M_MANUAL;
      fire_q       <= F_IDLE;
      timer_q      <= '0;
      step_q       <= '0;
      o_X_Cmd      <= CMD_IDLE;
      o_Y_Cmd      <= CMD_IDLE;
      o_X_Pos      <= '0;
      o_Y_Pos      <= '0;
      o_Shot_Pulse <= 1'b0;
    end else begin
      mode_q       <= mode_nxt;
      fire_q       <= fire_nxt;
      timer_q      <= timer_nxt;
      step_q       <= step_tick ? '0 : step_q + 1'b1;
      o_X_Cmd      <= x_cmd_nxt;
      o_Y_Cmd      <= y_cmd_nxt;
      o_Shot_Pulse <= (fire_q == F_IDLE) && (fire_nxt == F_FIRE);
      if (step_tick) begin
        o_X_Pos <= pos_step(o_X_Pos, o_X_Cmd, POS_W'(X_MAX));
        o_Y_Pos <= pos_step(o_Y_Pos, o_Y_Cmd, POS_W'(Y_MAX));
      end
    end
  end

  assign o_Fire_Cmd    = (fire_q == F_FIRE) ? 4'd1 : (fire_q == F_RECOIL) ? 4'd2 : 4'd0;
  assign o_Auto_Active = (mode_q == M_AUTO);
  assign o_Busy        = (fire_q != F_IDLE) || (mode_q == M_TO_AUTO) || (mode_q == M_TO_MANUAL);

endmodule

// File: tb/tb_turret_cmd_sequencer.sv
// Directed bench for turret_cmd_sequencer with small bounds and short fire timing.
module tb_turret_cmd_sequencer;

  localparam int POS_W = 25;

  logic             i_Clk = 1'b0;
  logic             i_Rst_n;
  logic             i_Auto_Mode, i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4, i_Fire_n;
  logic             i_Auto_Valid, i_Auto_On_Tgt, i_Auto_Fire;
  logic [1:0]       i_Auto_X_Dir, i_Auto_Y_Dir;
  logic [3:0]       o_X_Cmd, o_Y_Cmd, o_Fire_Cmd;
  logic [POS_W-1:0] o_X_Pos, o_Y_Pos;
  logic             o_Auto_Active, o_Shot_Pulse, o_Busy;

  int total = 0;
  int bad   = 0;

  turret_cmd_sequencer #(
    .POS_W(POS_W), .X_MAX(7), .Y_MAX(7), .STEP_DIV(1), .CNT_W(31),
    .FIRE_CYCLES(3), .RECOIL_CYCLES(2), .COOLDOWN_CYCLES(4)
  ) dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Auto_Mode(i_Auto_Mode),
    .i_Switch_1(i_Switch_1), .i_Switch_2(i_Switch_2), .i_Switch_3(i_Switch_3),
    .i_Switch_4(i_Switch_4), .i_Fire_n(i_Fire_n), .i_Auto_Valid(i_Auto_Valid),
    .i_Auto_X_Dir(i_Auto_X_Dir), .i_Auto_Y_Dir(i_Auto_Y_Dir), .i_Auto_On_Tgt(i_Auto_On_Tgt),
    .i_Auto_Fire(i_Auto_Fire), .o_X_Cmd(o_X_Cmd), .o_Y_Cmd(o_Y_Cmd), .o_Fire_Cmd(o_Fire_Cmd),
    .o_X_Pos(o_X_Pos), .o_Y_Pos(o_Y_Pos), .o_Auto_Active(o_Auto_Active),
    .o_Shot_Pulse(o_Shot_Pulse), .o_Busy(o_Busy)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic tick();
    @(posedge i_Clk);
    @(negedge i_Clk);
  endtask

  task automatic test_reset();
    i_Rst_n = 1'b0;
    repeat (2) @(negedge i_Clk);
    total++;
    if ({o_X_Cmd, o_Y_Cmd, o_Fire_Cmd, o_Auto_Active, o_Shot_Pulse, o_Busy} !== 15'd0) begin
      bad++; $display("FAIL reset_outputs got x=%0d y=%0d f=%0d aa=%0b sp=%0b busy=%0b want all 0",
                      o_X_Cmd, o_Y_Cmd, o_Fire_Cmd, o_Auto_Active, o_Shot_Pulse, o_Busy);
    end
    total++;
    if (o_X_Pos !== '0 || o_Y_Pos !== '0) begin
      bad++; $display("FAIL reset_pos got x=%0d y=%0d want 0 0", o_X_Pos, o_Y_Pos);
    end
    i_Rst_n = 1'b1;
    tick();
    total++;
    if (o_Busy !== 1'b0 || o_Auto_Active !== 1'b0 || o_X_Cmd !== 4'd0) begin
      bad++; $display("FAIL post_reset_idle got busy=%0b aa=%0b x=%0d want 0 0 0", o_Busy, o_Auto_Active, o_X_Cmd);
    end
  endtask

  task automatic test_manual_right();
    int exp_pos, exp_cmd;
    i_Switch_2 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_pos = (k - 1 > 7) ? 7 : k - 1;
      exp_cmd = (k <= 8) ? 2 : 0;
      total++;
      if (o_X_Pos !== POS_W'(exp_pos)) begin
        bad++; $display("FAIL right_pos[%0d] got %0d want %0d", k, o_X_Pos, exp_pos);
      end
      total++;
      if (o_X_Cmd !== 4'(exp_cmd)) begin
        bad++; $display("FAIL right_cmd[%0d] got %0d want %0d", k, o_X_Cmd, exp_cmd);
      end
    end
    i_Switch_2 = 1'b0;
    tick();
    total++;
    if (o_X_Cmd !== 4'd0 || o_X_Pos !== POS_W'(7)) begin
      bad++; $display("FAIL right_release got cmd=%0d pos=%0d want 0 7", o_X_Cmd, o_X_Pos);
    end
  endtask

  task automatic test_both_switches();
    i_Switch_1 = 1'b1;
    i_Switch_2 = 1'b1;
    repeat (2) tick();
    total++;
    if (o_X_Cmd !== 4'd0 || o_X_Pos !== POS_W'(7)) begin
      bad++; $display("FAIL both_sw got cmd=%0d pos=%0d want 0 7", o_X_Cmd, o_X_Pos);
    end
    i_Switch_1 = 1'b0;
    i_Switch_2 = 1'b0;
  endtask

  task automatic test_manual_left();
    i_Switch_1 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++;
      if (o_X_Cmd !== 4'd1 || o_X_Pos !== POS_W'(8 - k)) begin
        bad++; $display("FAIL left[%0d] got cmd=%0d pos=%0d want 1 %0d", k, o_X_Cmd, o_X_Pos, 8 - k);
      end
    end
    i_Switch_1 = 1'b0;
    tick();
    total++;
    if (o_X_Cmd !== 4'd0 || o_X_Pos !== POS_W'(4)) begin
      bad++; $display("FAIL left_release got cmd=%0d pos=%0d want 0 4", o_X_Cmd, o_X_Pos);
    end
  endtask

  task automatic test_y_lower_bound();
    i_Switch_3 = 1'b1;
    repeat (2) tick();
    total++;
    if (o_Y_Cmd !== 4'd0 || o_Y_Pos !== '0) begin
      bad++; $display("FAIL y_bound got cmd=%0d pos=%0d want 0 0", o_Y_Cmd, o_Y_Pos);
    end
    i_Switch_3 = 1'b0;
  endtask

  task automatic test_fire_cycle();
    int exp_f;
    i_Fire_n = 1'b0;
    tick();
    i_Fire_n = 1'b1;
    for (int i = 0; i <= 9; i++) begin
      if (i > 0) tick();
      exp_f = (i < 3) ? 1 : (i < 5) ? 2 : 0;
      total++;
      if (o_Fire_Cmd !== 4'(exp_f) || o_Busy !== (i < 9) || o_Shot_Pulse !== (i == 0)) begin
        bad++; $display("FAIL fire_seq[%0d] got f=%0d busy=%0b sp=%0b want %0d %0b %0b",
                        i, o_Fire_Cmd, o_Busy, o_Shot_Pulse, exp_f, i < 9, i == 0);
      end
      total++;
      if (o_X_Cmd !== ((i < 9) ? 4'd5 : 4'd0) || o_X_Pos !== POS_W'(4)) begin
        bad++; $display("FAIL fire_axis[%0d] got cmd=%0d pos=%0d want %0d 4",
                        i, o_X_Cmd, o_X_Pos, (i < 9) ? 5 : 0);
      end
    end
  endtask

  task automatic test_back_to_back();
    i_Fire_n = 1'b0;
    tick();
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) tick();
      total++;
      if (o_Shot_Pulse !== (i == 0 || i == 10) || o_Busy !== (i != 9)) begin
        bad++; $display("FAIL refire[%0d] got sp=%0b busy=%0b want %0b %0b",
                        i, o_Shot_Pulse, o_Busy, i == 0 || i == 10, i != 9);
      end
    end
    i_Fire_n = 1'b1;
    repeat (9) tick();
    total++;
    if (o_Busy !== 1'b0 || o_Fire_Cmd !== 4'd0) begin
      bad++; $display("FAIL refire_drain got busy=%0b f=%0d want 0 0", o_Busy, o_Fire_Cmd);
    end
  endtask

  task automatic test_mode_defer();
    i_Auto_X_Dir = 2'b10;
    i_Fire_n = 1'b0;
    tick();
    i_Fire_n = 1'b1;
    i_Auto_Mode = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      total++;
      if (o_Auto_Active !== 1'b0) begin
        bad++; $display("FAIL defer[%0d] got aa=%0b want 0", i, o_Auto_Active);
      end
    end
    tick();
    total++;
    if (o_X_Cmd !== 4'd5 || o_Y_Cmd !== 4'd5 || o_Busy !== 1'b1 || o_Auto_Active !== 1'b0) begin
      bad++; $display("FAIL to_auto got x=%0d y=%0d busy=%0b aa=%0b want 5 5 1 0",
                      o_X_Cmd, o_Y_Cmd, o_Busy, o_Auto_Active);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (o_Auto_Active !== 1'b1 || o_X_Cmd !== 4'd0 || o_Busy !== 1'b0) begin
        bad++; $display("FAIL auto_novalid[%0d] got aa=%0b x=%0d busy=%0b want 1 0 0",
                        i, o_Auto_Active, o_X_Cmd, o_Busy);
      end
    end
  endtask

  task automatic test_auto_fire();
    i_Auto_Valid = 1'b1;
    tick();
    total++;
    if (o_X_Cmd !== 4'd2) begin
      bad++; $display("FAIL auto_right got %0d want 2", o_X_Cmd);
    end
    i_Auto_X_Dir  = 2'b00;
    i_Auto_On_Tgt = 1'b1;
    i_Auto_Fire   = 1'b1;
    tick();
    total++;
    if (o_Fire_Cmd !== 4'd1 || o_Shot_Pulse !== 1'b1 || o_X_Cmd !== 4'd5 || o_Y_Cmd !== 4'd5) begin
      bad++; $display("FAIL auto_shot got f=%0d sp=%0b x=%0d y=%0d want 1 1 5 5",
                      o_Fire_Cmd, o_Shot_Pulse, o_X_Cmd, o_Y_Cmd);
    end
    i_Auto_Valid  = 1'b0;
    i_Auto_On_Tgt = 1'b0;
    i_Auto_Fire   = 1'b0;
    tick();
    total++;
    if (o_Shot_Pulse !== 1'b0 || o_X_Cmd !== 4'd5 || o_Fire_Cmd !== 4'd1) begin
      bad++; $display("FAIL auto_shot2 got sp=%0b x=%0d f=%0d want 0 5 1", o_Shot_Pulse, o_X_Cmd, o_Fire_Cmd);
    end
    repeat (2) tick();
    total++;
    if (o_Fire_Cmd !== 4'd2 || o_X_Pos !== POS_W'(5)) begin
      bad++; $display("FAIL auto_recoil got f=%0d pos=%0d want 2 5", o_Fire_Cmd, o_X_Pos);
    end
  endtask

  task automatic test_reset_mid_recoil();
    #2;
    i_Rst_n = 1'b0;
    #1;
    total++;
    if ({o_X_Cmd, o_Y_Cmd, o_Fire_Cmd, o_Auto_Active, o_Shot_Pulse, o_Busy} !== 15'd0 ||
        o_X_Pos !== '0 || o_Y_Pos !== '0) begin
      bad++; $display("FAIL async_reset got x=%0d y=%0d f=%0d aa=%0b busy=%0b xp=%0d want all 0",
                      o_X_Cmd, o_Y_Cmd, o_Fire_Cmd, o_Auto_Active, o_Busy, o_X_Pos);
    end
    @(negedge i_Clk);
    i_Auto_Mode = 1'b0;
    @(negedge i_Clk);
    i_Rst_n = 1'b1;
    tick();
    total++;
    if (o_Auto_Active !== 1'b0 || o_Busy !== 1'b0 || o_Fire_Cmd !== 4'd0 ||
        o_X_Pos !== '0 || o_X_Cmd !== 4'd0) begin
      bad++; $display("FAIL after_reset got aa=%0b busy=%0b f=%0d xp=%0d x=%0d want 0 0 0 0 0",
                      o_Auto_Active, o_Busy, o_Fire_Cmd, o_X_Pos, o_X_Cmd);
    end
  endtask

  initial begin
    i_Rst_n = 1'b0; i_Auto_Mode = 1'b0; i_Fire_n = 1'b1;
    i_Switch_1 = 1'b0; i_Switch_2 = 1'b0; i_Switch_3 = 1'b0; i_Switch_4 = 1'b0;
    i_Auto_Valid = 1'b0; i_Auto_X_Dir = 2'b00; i_Auto_Y_Dir = 2'b00;
    i_Auto_On_Tgt = 1'b0; i_Auto_Fire = 1'b0;
    test_reset();
    test_manual_right();
    test_both_switches();
    test_manual_left();
    test_y_lower_bound();
    test_fire_cycle();
    test_back_to_back();
    test_mode_defer();
    test_auto_fire();
    test_reset_mid_recoil();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
